// File: rtl/if_id_fetch_queue_pkg.sv
// rtl/if_id_fetch_queue_pkg.sv - shared RV32I word and fetch packet types for the IF/ID queue
package if_id_fetch_queue_pkg;

    typedef logic [31:0] rv32i_word;

    typedef struct packed {
        rv32i_word pc;
        rv32i_word instr;
    } fetch_pkt_t;

    // addi x0,x0,0
    localparam rv32i_word NOP_INSTR = 32'h00000013;

    localparam int FETCH_PKT_W = $bits(fetch_pkt_t);

endpackage

// File: rtl/if_id_fetch_queue_if.sv
// rtl/if_id_fetch_queue_if.sv - IF-side push and ID-side pop handshake bundle for the fetch queue
interface if_id_fetch_queue_if #(
    parameter int DEPTH = 2
);
    import if_id_fetch_queue_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    rv32i_word        IF_pc_i;
    rv32i_word        IF_instr_i;
    logic             IF_valid_i;
    logic             IF_ready_o;
    rv32i_word        ID_pc_o;
    rv32i_word        ID_instr_o;
    logic             ID_valid_o;
    logic             ID_ready_i;
    logic             flush_i;
    logic [CW-1:0]    count_o;

    // Pipeline side: drives fetches, consumes decodes, issues redirects
    modport master (
        output IF_pc_i, IF_instr_i, IF_valid_i, ID_ready_i, flush_i,
        input  IF_ready_o, ID_pc_o, ID_instr_o, ID_valid_o, count_o
    );

    // Queue side
    modport slave (
        input  IF_pc_i, IF_instr_i, IF_valid_i, ID_ready_i, flush_i,
        output IF_ready_o, ID_pc_o, ID_instr_o, ID_valid_o, count_o
    );

endinterface

// File: rtl/if_id_fetch_queue_sync_fifo.sv
// rtl/if_id_fetch_queue_sync_fifo.sv - generic synchronous FIFO with push/pop/clear and occupancy
module sync_fifo #(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 2,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    // Pointers and occupancy; clear wins over push/pop, pointers wrap modulo DEPTH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage needs no reset: an entry is only read after it has been written
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Status flags and head-of-queue read
    always_comb begin
        full  = (count == CW'(DEPTH));
        empty = (count == '0);
        rdata = mem[rd_ptr];
    end

    a_count_bound: assert property (@(posedge clk) disable iff (!rst_n) count <= CW'(DEPTH));
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !pop));

endmodule

// File: rtl/if_id_fetch_queue.sv
// rtl/if_id_fetch_queue.sv - IF-to-ID decoupling queue with redirect flush and NOP on empty
module if_id_fetch_queue
    import if_id_fetch_queue_pkg::rv32i_word, if_id_fetch_queue_pkg::fetch_pkt_t;
#(
    parameter int        DEPTH     = 2,
    parameter rv32i_word NOP_INSTR = if_id_fetch_queue_pkg::NOP_INSTR
) (
    input  logic              clk,
    input  logic              rst,
    if_id_fetch_queue_if.slave q
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_pkt_t    wr_pkt;
    fetch_pkt_t    head_pkt;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          push;
    logic          pop;

    // Handshake qualification; ready comes only from registered occupancy so ID
    // never has a combinational path back to IF
    always_comb begin
        q.IF_ready_o = rst & ~fifo_full;
        q.ID_valid_o = ~fifo_empty;
        push         = q.IF_valid_i & q.IF_ready_o & ~q.flush_i;
        pop          = q.ID_valid_o & q.ID_ready_i & ~q.flush_i;
        wr_pkt.pc    = q.IF_pc_i;
        wr_pkt.instr = q.IF_instr_i;
        q.count_o    = fifo_count;
    end

    sync_fifo #(
        .WIDTH ($bits(fetch_pkt_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst),
        .push  (push),
        .pop   (pop),
        .clear (q.flush_i),
        .wdata (wr_pkt),
        .rdata (head_pkt),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Decode sees a NOP at PC 0 whenever nothing is queued, never stale storage
    always_comb begin
        q.ID_pc_o    = head_pkt.pc;
        q.ID_instr_o = head_pkt.instr;
        if (fifo_empty) begin
            q.ID_pc_o    = '0;
            q.ID_instr_o = NOP_INSTR;
        end
    end

endmodule
